link_pattern_checker: RTL and testbench

//  Receive-side counterpart of the dummy pattern generator on the loopback bench.

---
 rtl/link_pattern_checker.sv | 152 +++++++++++++++
 tb/tb_link_pattern_checker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_pattern_checker.sv
// Loopback receive checker: finds the latency of i_rx against i_ref, then
// checks every cycle with +/-TOL cycles of per-bit edge tolerance.
module link_pattern_checker #(
  parameter int WIDTH    = 8,
  parameter int MAX_LAT  = 64,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 16
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic [WIDTH-1:0] i_ref,
  input  logic [WIDTH-1:0] i_rx,
  input  logic             i_clr,
  output logic             o_locked,
  output logic [7:0]       o_lat,
  output logic             o_err,
  output logic [15:0]      o_err_cnt,
  output logic [31:0]      o_chk_cnt,
  output logic             o_no_lock
);

  localparam int HL = MAX_LAT + TOL;
  localparam int RW = $clog2(LOCK_CNT + 1);

  localparam logic [0:0] ST_SEARCH = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [7:0]    L_FIRST = 8'(TOL + 1);
  localparam logic [7:0]    L_LAST  = 8'(MAX_LAT - TOL);
  localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_CNT);

  logic [WIDTH-1:0] hist_q [HL];
  logic [WIDTH-1:0] hist_d [HL];
  logic [0:0]       state_q, state_d;
  logic [7:0]       cand_q, cand_d;
  logic [RW-1:0]    run_q, run_d;
  logic             seen_q, seen_d;
  logic [7:0]       lat_q, lat_d;
  logic             err_q, err_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [31:0]      chk_cnt_q, chk_cnt_d;
  logic             no_lock_q, no_lock_d;

  logic [WIDTH-1:0] ref_at_l;
  logic [WIDTH-1:0] win_ok;
  logic             match;
  logic             bad;
  logic             hist_tr;

  always_comb begin
    hist_d[0] = i_ref;
    for (int k = 1; k < HL; k++) hist_d[k] = hist_q[k-1];
  end

  // Candidate tap for the exact search compare, and the OR of per-bit
  // agreement across the whole tolerance window around it.
  always_comb begin
    ref_at_l = '0;
    win_ok   = '0;
    for (int k = 0; k < HL; k++) begin
      if (k == int'(cand_q) - 1) ref_at_l = hist_q[k];
      if (k >= int'(cand_q) - 1 - TOL && k <= int'(cand_q) - 1 + TOL)
        win_ok = win_ok | ~(i_rx ^ hist_q[k]);
    end
  end

  assign match   = (i_rx == ref_at_l);
  assign bad     = ~&win_ok;
  assign hist_tr = (hist_q[0] != hist_q[1]);

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    run_d     = run_q;
    seen_d    = seen_q;
    lat_d     = lat_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    chk_cnt_d = chk_cnt_q;
    no_lock_d = no_lock_q;
    if (i_clr) begin
      state_d   = ST_SEARCH;
      cand_d    = L_FIRST;
      run_d     = '0;
      seen_d    = 1'b0;
      lat_d     = '0;
      err_cnt_d = '0;
      chk_cnt_d = '0;
      no_lock_d = 1'b0;
    end else if (state_q == ST_SEARCH) begin
      if (match) begin
        if (run_q != RUN_MAX) run_d = run_q + RW'(1);
        seen_d = seen_q | hist_tr;
        // A static pattern matches every candidate; demand a transition.
        if (run_d == RUN_MAX && seen_d) begin
          state_d   = ST_LOCKED;
          lat_d     = cand_q;
          no_lock_d = 1'b0;
        end
      end else begin
        run_d  = '0;
        seen_d = 1'b0;
        if (cand_q == L_LAST) begin
          cand_d    = L_FIRST;
          no_lock_d = 1'b1;
        end else begin
          cand_d = cand_q + 8'd1;
        end
      end
    end else begin
      if (chk_cnt_q != 32'hFFFF_FFFF) chk_cnt_d = chk_cnt_q + 32'd1;
      if (bad) begin
        err_d = 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      for (int k = 0; k < HL; k++) hist_q[k] <= '0;
      state_q   <= ST_SEARCH;
      cand_q    <= L_FIRST;
      run_q     <= '0;
      seen_q    <= 1'b0;
      lat_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
      no_lock_q <= 1'b0;
    end else begin
      for (int k = 0; k < HL; k++) hist_q[k] <= hist_d[k];
      state_q   <= state_d;
      cand_q    <= cand_d;
      run_q     <= run_d;
      seen_q    <= seen_d;
      lat_q     <= lat_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      chk_cnt_q <= chk_cnt_d;
      no_lock_q <= no_lock_d;
    end
  end

  assign o_locked  = (state_q == ST_LOCKED);
  assign o_lat     = lat_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;
  assign o_chk_cnt = chk_cnt_q;
  assign o_no_lock = no_lock_q;

endmodule

// File: tb/tb_link_pattern_checker.sv
// Directed bench for link_pattern_checker: a queue-based link/latency model
// checked every cycle, plus literal expectations for each scenario.
module tb_link_pattern_checker;
  localparam int W  = 8;
  localparam int ML = 64;
  localparam int T  = 1;
  localparam int LC = 16;
  localparam int HL = ML + T;

  logic        i_clk = 1'b0;
  logic        i_res_n = 1'b0;
  logic        i_clr = 1'b0;
  logic [7:0]  i_ref = '0;
  logic [7:0]  i_rx = '0;
  logic        o_locked, o_err, o_no_lock;
  logic [7:0]  o_lat;
  logic [15:0] o_err_cnt;
  logic [31:0] o_chk_cnt;

  link_pattern_checker #(.WIDTH(W), .MAX_LAT(ML), .TOL(T), .LOCK_CNT(LC)) dut (
    .i_clk(i_clk), .i_res_n(i_res_n), .i_ref(i_ref), .i_rx(i_rx), .i_clr(i_clr),
    .o_locked(o_locked), .o_lat(o_lat), .o_err(o_err), .o_err_cnt(o_err_cnt),
    .o_chk_cnt(o_chk_cnt), .o_no_lock(o_no_lock)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // model: mh[k] = ref delayed k+1 cycles
  logic [7:0] mh[$];
  bit         m_locked, m_seen, m_err, m_no_lock;
  int         m_L, m_run, m_err_cnt;
  longint     m_chk;

  // link: sent[d-1] = ref driven d cycles ago
  logic [7:0] sent[$];
  logic [7:0] ramp = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mh.delete();
    repeat (HL) mh.push_back(8'h00);
    m_locked = 0; m_seen = 0; m_err = 0; m_no_lock = 0;
    m_L = T + 1; m_run = 0; m_err_cnt = 0; m_chk = 0;
  endtask

  task automatic link_reset();
    sent.delete();
    repeat (128) sent.push_back(8'h00);
  endtask

  task automatic model_step(input bit clr, input logic [7:0] r, input logic [7:0] x);
    bit bad, ok;
    logic [7:0] h;
    if (clr) begin
      m_locked = 0; m_seen = 0; m_err = 0; m_no_lock = 0;
      m_L = T + 1; m_run = 0; m_err_cnt = 0; m_chk = 0;
    end else if (!m_locked) begin
      m_err = 0;
      if (x == mh[m_L-1]) begin
        if (m_run < LC) m_run++;
        if (mh[0] != mh[1]) m_seen = 1;
        if (m_run == LC && m_seen) begin
          m_locked = 1;
          m_no_lock = 0;
        end
      end else begin
        m_run = 0;
        m_seen = 0;
        if (m_L == ML - T) begin
          m_L = T + 1;
          m_no_lock = 1;
        end else m_L++;
      end
    end else begin
      bad = 0;
      for (int b = 0; b < W; b++) begin
        ok = 0;
        for (int j = m_L - 1 - T; j <= m_L - 1 + T; j++) begin
          h = mh[j];
          if (h[b] == x[b]) ok = 1;
        end
        if (!ok) bad = 1;
      end
      m_err = bad;
      if (m_chk < 64'hFFFF_FFFF) m_chk++;
      if (bad && m_err_cnt < 16'hFFFF) m_err_cnt++;
    end
    mh.push_front(r);
    void'(mh.pop_back());
  endtask

  // One clock: drive, let the edge pass, update model and link, compare.
  task automatic cyc(input logic [7:0] r, input logic [7:0] x, input bit c);
    i_ref = r; i_rx = x; i_clr = c;
    @(posedge i_clk);
    if (i_res_n) begin
      model_step(c, r, x);
      sent.push_front(r);
      void'(sent.pop_back());
    end else begin
      model_reset();
      link_reset();
    end
    #1;
    check("locked", o_locked, m_locked);
    check("lat", o_lat, m_locked ? m_L : 0);
    check("err", o_err, m_err);
    check("err_cnt", o_err_cnt, m_err_cnt);
    check("chk_cnt", o_chk_cnt, m_chk);
    check("no_lock", o_no_lock, m_no_lock);
  endtask

  task automatic run_ramp(input int n, input int dly);
    repeat (n) begin
      ramp++;
      cyc(ramp, sent[dly-1], 1'b0);
    end
  endtask

  task automatic wait_lock(input int budget, input int dly);
    for (int i = 0; i < budget && !o_locked; i++) run_ramp(1, dly);
  endtask

  // Delay the next rising edge of rx bit 3 by k cycles.
  task automatic shift_edge(input int k, output int pulses, output int dcnt);
    int hold;
    bit arm;
    logic [7:0] x, y;
    logic [15:0] c0;
    hold = 0; arm = 1; pulses = 0; c0 = o_err_cnt;
    repeat (40) begin
      ramp++;
      x = sent[4];
      y = sent[5];
      if (hold > 0) begin
        x[3] = 1'b0;
        hold--;
      end else if (arm && x[3] && !y[3]) begin
        x[3] = 1'b0;
        hold = k - 1;
        arm = 0;
      end
      cyc(ramp, x, 1'b0);
      if (o_err) pulses++;
    end
    dcnt = int'(o_err_cnt - c0);
  endtask

  initial begin
    int p, d;
    logic [31:0] c0;
    model_reset();
    link_reset();

    repeat (3) cyc(8'h00, 8'h00, 1'b0);
    check("rst_lat", o_lat, 0);
    check("rst_chk", o_chk_cnt, 0);
    i_res_n = 1'b1;

    // static pattern never locks
    repeat (1000) cyc(8'h00, 8'h00, 1'b0);
    check("static_locked", o_locked, 0);
    check("static_errcnt", o_err_cnt, 0);

    // ramp through a 5-cycle link
    cyc(8'h00, 8'h00, 1'b1);
    wait_lock(80, 5);
    check("t1_locked", o_locked, 1);
    check("t1_lat", o_lat, 5);
    c0 = o_chk_cnt;
    run_ramp(20, 5);
    check("t1_chk_delta", o_chk_cnt - c0, 20);
    check("t1_errcnt", o_err_cnt, 0);

    // edge jitter within and beyond tolerance
    shift_edge(1, p, d);
    check("jit1_pulses", p, 0);
    check("jit1_delta", d, 0);
    shift_edge(2, p, d);
    check("jit2_pulses", p, 1);
    check("jit2_delta", d, 1);

    // build three errors, then clear together with a fourth
    for (int i = 0; i < 20 && m_err_cnt < 3; i++) begin
      ramp++;
      cyc(ramp, sent[4] ^ 8'hFF, 1'b0);
    end
    check("t5_errcnt3", o_err_cnt, 3);
    ramp++;
    cyc(ramp, sent[4] ^ 8'hFF, 1'b1);
    check("clr_errcnt", o_err_cnt, 0);
    check("clr_err", o_err, 0);
    check("clr_locked", o_locked, 0);
    check("clr_chk", o_chk_cnt, 0);
    wait_lock(LC + 8, 5);
    check("relock_locked", o_locked, 1);
    check("relock_lat", o_lat, 5);

    // asynchronous reset between edges
    i_res_n = 1'b0;
    #1;
    check("arst_locked", o_locked, 0);
    check("arst_lat", o_lat, 0);
    check("arst_err", o_err, 0);
    check("arst_errcnt", o_err_cnt, 0);
    check("arst_chk", o_chk_cnt, 0);
    check("arst_nolock", o_no_lock, 0);
    repeat (2) cyc(8'h00, 8'h00, 1'b0);
    i_res_n = 1'b1;
    ramp = 8'h00;
    wait_lock(40, 5);
    check("rst_relock", o_locked, 1);
    check("rst_relock_lat", o_lat, 5);

    // latency beyond the search range
    cyc(ramp, sent[99], 1'b1);
    run_ramp(200, 100);
    check("far_nolock", o_no_lock, 1);
    check("far_locked", o_locked, 0);
    check("far_lat", o_lat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
